// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, DIGIT bits per clock, single registered carry.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 request, accepted when ready=1
//   a, b, cin             operands and carry-in, sampled at acceptance
//   ready                 1 = idle, can accept start
//   done                  one-cycle pulse when sum/cout/overflow update
//   sum, cout, overflow   a+b+cin mod 2^WIDTH, carry out, two's-complement overflow
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // Reject illegal parameter combinations at elaboration
  generate
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_adder: DIGIT must divide WIDTH and satisfy 1<=DIGIT<=WIDTH");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_sr, a_sr_d;
  logic [WIDTH-1:0] b_sr, b_sr_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic             carry, carry_d;
  logic [CW-1:0]    step, step_d;
  logic             ready_d, done_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, overflow_d;

  logic [DIGIT:0]   slice_c;
  logic             c_msb_c;
  logic             last_c;

  // One DIGIT-wide slice of the addition plus the carry into its top bit
  always_comb begin
    slice_c = (DIGIT+1)'(a_sr[DIGIT-1:0]) + (DIGIT+1)'(b_sr[DIGIT-1:0]) + (DIGIT+1)'(carry);
    c_msb_c = slice_c[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];
    last_c  = (step == CW'(N - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and next-value logic
  always_comb begin
    state_d    = state;
    a_sr_d     = a_sr;
    b_sr_d     = b_sr;
    acc_d      = acc;
    carry_d    = carry;
    step_d     = step;
    ready_d    = ready;
    done_d     = 1'b0;
    sum_d      = sum;
    cout_d     = cout;
    overflow_d = overflow;
    case (state)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          acc_d   = '0;
          step_d  = '0;
          ready_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr >> DIGIT;
        b_sr_d  = b_sr >> DIGIT;
        // Slices enter at the top so the first one ends up in the LSBs
        acc_d   = (acc >> DIGIT) | (WIDTH'(slice_c[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_d = slice_c[DIGIT];
        step_d  = step + CW'(1);
        if (last_c) begin
          sum_d      = acc_d;
          cout_d     = slice_c[DIGIT];
          overflow_d = c_msb_c ^ slice_c[DIGIT];
          done_d     = 1'b1;
          ready_d    = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      step     <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      a_sr     <= a_sr_d;
      b_sr     <= b_sr_d;
      acc      <= acc_d;
      carry    <= carry_d;
      step     <= step_d;
      ready    <= ready_d;
      done     <= done_d;
      sum      <= sum_d;
      cout     <= cout_d;
      overflow <= overflow_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for serial_adder in three configurations
// (8/1, 8/4, 1/1) sharing clock, reset and operand buses.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       start8 = 1'b0, start4 = 1'b0, start1 = 1'b0;

  logic       ready8, done8, cout8, ov8;
  logic [7:0] sum8;
  logic       ready4, done4, cout4, ov4;
  logic [7:0] sum4;
  logic       ready1, done1, cout1, ov1;
  logic [0:0] sum1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a), .b(b), .cin(cin),
    .ready(ready8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .cin(cin),
    .ready(ready4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ov4));

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a[0:0]), .b(b[0:0]), .cin(cin),
    .ready(ready1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ov1));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t t8[7];
  vec_t t1[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // sel: 0 = 8/1, 1 = 8/4, 2 = 1/1
  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start8 = v;
      1:       start4 = v;
      default: start1 = v;
    endcase
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return ready8;
      1:       return ready4;
      default: return ready1;
    endcase
  endfunction

  function automatic logic dn(input int sel);
    case (sel)
      0:       return done8;
      1:       return done4;
      default: return done1;
    endcase
  endfunction

  function automatic logic [7:0] sm(input int sel);
    case (sel)
      0:       return sum8;
      1:       return sum4;
      default: return 8'(sum1);
    endcase
  endfunction

  function automatic logic co(input int sel);
    case (sel)
      0:       return cout8;
      1:       return cout4;
      default: return cout1;
    endcase
  endfunction

  function automatic logic ov(input int sel);
    case (sel)
      0:       return ov8;
      1:       return ov4;
      default: return ov1;
    endcase
  endfunction

  // One start pulse, then check latency, busy/hold behaviour, results and done width
  task automatic do_add(input int sel, input string tag, input vec_t v, input int lat);
    int         k;
    logic       got;
    logic       bad;
    logic [7:0] prev;
    prev = sm(sel);
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    a = ~v.a; b = ~v.b; cin = ~v.cin;
    check({tag, " ready_after_accept"}, 32'(rdy(sel)), 32'd0);
    k = 0; got = 1'b0; bad = 1'b0;
    while (!got && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (dn(sel)) got = 1'b1;
      else if (rdy(sel) || sm(sel) !== prev) bad = 1'b1;
    end
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " busy_hold"}, 32'(bad), 32'd0);
    check({tag, " sum"}, 32'(sm(sel)), 32'(v.s));
    check({tag, " cout"}, 32'(co(sel)), 32'(v.c));
    check({tag, " overflow"}, 32'(ov(sel)), 32'(v.o));
    @(posedge clk); #1;
    check({tag, " done_width"}, 32'(dn(sel)), 32'd0);
  endtask

  initial begin
    int   k;
    int   ndone;
    int   kdone;
    logic bad;

    t8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    t8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    t8[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
    t8[3] = '{8'h55, 8'h0A, 1'b0, 8'h5F, 1'b0, 1'b0};
    t8[4] = '{8'h3C, 8'h4B, 1'b1, 8'h88, 1'b0, 1'b1};
    t8[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    t8[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    // abc = 000..111 for the 1-bit instance
    t1[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    t1[1] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1};
    t1[2] = '{8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0};
    t1[3] = '{8'h00, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
    t1[4] = '{8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
    t1[5] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    t1[6] = '{8'h01, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
    t1[7] = '{8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};

    // Reset values
    #12;
    check("rst ready", 32'(ready8), 32'd1);
    check("rst done", 32'(done8), 32'd0);
    check("rst sum", 32'(sum8), 32'd0);
    check("rst cout_ov", 32'({cout8, ov8}), 32'd0);
    check("rst ready4", 32'(ready4), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) do_add(0, $sformatf("d8[%0d]", i), t8[i], 8);
    for (int i = 0; i < 7; i++) do_add(1, $sformatf("d4[%0d]", i), t8[i], 2);
    for (int i = 0; i < 8; i++) do_add(2, $sformatf("d1[%0d]", i), t1[i], 1);

    // Back-to-back on the 8/4 instance: restart in the done cycle
    @(negedge clk);
    a = 8'h3C; b = 8'h4B; cin = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    check("b2b first_e1_done", 32'(done4), 32'd0);
    @(posedge clk); #1;
    check("b2b first_done", 32'(done4), 32'd1);
    check("b2b first_sum", 32'(sum4), 32'h88);
    check("b2b ready_in_done", 32'(ready4), 32'd1);
    a = 8'h01; b = 8'h01; cin = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("b2b accepted", 32'(ready4), 32'd0);
    check("b2b done_dropped", 32'(done4), 32'd0);
    @(posedge clk); #1;
    check("b2b sum_held", 32'(sum4), 32'h88);
    @(posedge clk); #1;
    check("b2b second_done", 32'(done4), 32'd1);
    check("b2b second_sum", 32'(sum4), 32'h02);

    // Start while busy is ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0; kdone = 0;
    for (int j = 1; j <= 16; j++) begin
      if (j == 2) begin a = 8'hFF; b = 8'hFF; start8 = 1'b1; end
      if (j == 3) start8 = 1'b0;
      @(posedge clk); #1;
      if (done8) begin ndone++; kdone = j; end
    end
    check("busy done_count", 32'(ndone), 32'd1);
    check("busy latency", 32'(kdone), 32'd8);
    check("busy sum", 32'(sum8), 32'h30);
    check("busy cout", 32'(cout8), 32'd0);
    check("busy ready_end", 32'(ready8), 32'd1);

    // Reset mid-operation
    do_add(0, "pre_rst", t8[3], 8);
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int j = 0; j < 3; j++) begin @(posedge clk); end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst ready", 32'(ready8), 32'd1);
    check("midrst done", 32'(done8), 32'd0);
    check("midrst sum", 32'(sum8), 32'd0);
    check("midrst cout_ov", 32'({cout8, ov8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    k = 0;
    while (k < 12) begin
      @(posedge clk); #1;
      k++;
      if (done8 || sum8 !== 8'h00 || !ready8) bad = 1'b1;
    end
    check("midrst no_done_after", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
